div_share_ctrl: RTL
===================

Name: div_share_ctrl

Overview:
- Round-robin controller that shares one iterative unsigned divider core among N_REQ requesters.
- Accepts a request, latches its operands and launches the divider with a one-cycle start pulse.
- Waits for done, then returns quotient and remainder to the winning requester.
- Handles divide-by-zero locally without launching the core; a watchdog recovers from a core that never signals done.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, operand/result width.
- TIMEOUT, 32, max cycles in WAIT before abort (must exceed core latency).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  request per requester, level
- req_x  in  N_REQ*W  dividends, requester i at [i*W +: W]
- req_y  in  N_REQ*W  divisors, same packing
- gnt  out  N_REQ  one-hot, one-cycle pulse: operands captured
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse: result ready
- rsp_q  out  W  quotient, valid with rsp_valid
- rsp_r  out  W  remainder, valid with rsp_valid
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
- div_start  out  1  one-cycle launch pulse to core
- div_x  out  W  dividend to core, held stable START..WAIT
- div_y  out  W  divisor to core, held stable START..WAIT
- div_done  in  1  core result valid (pulse or level; first high in WAIT taken)
- div_q  in  W  core quotient
- div_r  in  W  core remainder

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; rr pointer 0; timeout counter 0.
- rst_n low mid-operation aborts immediately: no rsp_valid is issued for the in-flight request. A div_done arriving later in IDLE is ignored.
- State registers: IDLE, START, WAIT, RESP. All outputs are registered.
- IDLE:
  - Samples req. Winner = first requester with req high at or after pointer, wrapping modulo N_REQ.
  - On that edge: latch winner index and operands into div_x/div_y; gnt[winner]=1 for exactly one cycle.
  - If latched Y==0: go to RESP with Q=all-ones, R=X, err=01.
  - Else: go to START.
  - No req: stay in IDLE, all pulses 0.
- START: div_start=1 for one cycle; clear timeout counter; go to WAIT.
- WAIT:
  - First cycle div_done is high: capture div_q/div_r, err=00, go to RESP.
  - Else increment counter. At TIMEOUT-1 with no done: Q=0, R=0, err=10, go to RESP.
  - div_done high outside WAIT is ignored.
- RESP:
  - rsp_valid[winner]=1 for one cycle.
  - rsp_q/rsp_r/rsp_err hold their values until the next RESP; they are only meaningful with rsp_valid.
  - pointer <= (winner+1) mod N_REQ; go to IDLE.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - May deassert req from the cycle after gnt.
  - req still high when the FSM re-enters IDLE is treated as a new request.
- req changing while the FSM is not in IDLE has no effect.
- Only one operation is in flight. Throughput is one result per (core latency + 3) cycles.
- Latency, Y≠0, core done D cycles after start:
  - gnt at edge k
  - div_start at edge k+1
  - done sampled at edge k+1+D
  - rsp_valid at edge k+2+D
- Latency, Y==0: rsp_valid one cycle after gnt.
- Fairness: a requester that holds req continuously is granted within N_REQ operations.

Test Plan:
- Single request: req[0], X=22, Y=3, core model D=9 → gnt[0] pulse; div_start next cycle with div_x=22, div_y=3; rsp_valid[0] 10 cycles after div_start; Q=7, R=1, err=00.
- Divide-by-zero: req[2], X=200, Y=0 → gnt[2], no div_start, rsp_valid[2] next cycle; Q=255, R=200, err=01.
- Round-robin: all four req held high from reset, distinct operands → grant order 0,1,2,3,0; each rsp_valid one-hot to the matching requester with correct Q/R (e.g. 255/16 → 15 r15, 100/7 → 14 r2).
- Timeout: req[1], X=9, Y=2, core never asserts done → rsp_valid[1] TIMEOUT+1 cycles after div_start; Q=0, R=0, err=10; FSM back in IDLE; a late div_done is ignored.
- Reset mid-WAIT: rst_n low for 2 cycles during WAIT of req[3] → all outputs 0 asynchronously, no rsp_valid[3]. After release, req[0] and req[3] both high → req[0] granted (pointer reset to 0).
- Boundaries: X=255, Y=1 → Q=255, R=0. X=5, Y=9 → Q=0, R=5. Back-to-back requests from the same requester held high with others idle → re-granted each cycle it re-enters IDLE.

Source files
------------

// File: rtl/div_share_ctrl_if.sv
// Requester-side and divider-core-side signals of the shared divider controller.
// The controller connects through the slave modport; requesters and core drive the master side.
interface div_share_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] req_x;
    logic [N_REQ*W-1:0] req_y;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rsp_valid;
    logic [W-1:0]       rsp_q;
    logic [W-1:0]       rsp_r;
    logic [1:0]         rsp_err;
    logic               div_start;
    logic [W-1:0]       div_x;
    logic [W-1:0]       div_y;
    logic               div_done;
    logic [W-1:0]       div_q;
    logic [W-1:0]       div_r;

    modport master (
        output req, req_x, req_y, div_done, div_q, div_r,
        input  gnt, rsp_valid, rsp_q, rsp_r, rsp_err, div_start, div_x, div_y
    );

    modport slave (
        input  req, req_x, req_y, div_done, div_q, div_r,
        output gnt, rsp_valid, rsp_q, rsp_r, rsp_err, div_start, div_x, div_y
    );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one iterative divider core among N_REQ requesters,
// with local divide-by-zero handling and a watchdog on the core's done signal.
module div_share_ctrl #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 32
) (
    input logic             clk,
    input logic             rst_n,
    div_share_ctrl_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          win_found;
    logic [CW-1:0] tcnt;
    logic [W-1:0]  res_q;
    logic [W-1:0]  res_r;
    logic [1:0]    res_err;
    logic [W-1:0]  win_x;
    logic [W-1:0]  win_y;

    // Search starts at the pointer and wraps, so the last winner becomes lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(ptr) + i) % N_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_x = bus.req_x[int'(win_idx)*W +: W];
    assign win_y = bus.req_y[int'(win_idx)*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            winner        <= '0;
            tcnt          <= '0;
            res_q         <= '0;
            res_r         <= '0;
            res_err       <= 2'b00;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_q     <= '0;
            bus.rsp_r     <= '0;
            bus.rsp_err   <= 2'b00;
            bus.div_start <= 1'b0;
            bus.div_x     <= '0;
            bus.div_y     <= '0;
        end else begin
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        winner    <= win_idx;
                        bus.gnt   <= ONE_HOT0 << win_idx;
                        bus.div_x <= win_x;
                        bus.div_y <= win_y;
                        // A zero divisor never reaches the core; answer it directly.
                        if (win_y == '0) begin
                            res_q   <= '1;
                            res_r   <= win_x;
                            res_err <= 2'b01;
                            state   <= RESP;
                        end else begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    bus.div_start <= 1'b1;
                    tcnt          <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (bus.div_done) begin
                        res_q   <= bus.div_q;
                        res_r   <= bus.div_r;
                        res_err <= 2'b00;
                        state   <= RESP;
                    end else if (tcnt == CW'(TIMEOUT - 1)) begin
                        res_q   <= '0;
                        res_r   <= '0;
                        res_err <= 2'b10;
                        state   <= RESP;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                RESP: begin
                    bus.rsp_valid <= ONE_HOT0 << winner;
                    bus.rsp_q     <= res_q;
                    bus.rsp_r     <= res_r;
                    bus.rsp_err   <= res_err;
                    ptr           <= (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
